// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Package     : mips_defs
//  Description : Shared definitions for the 5-stage MIPS core: datapath and
//                ALU-op width defaults, ALU-op encodings, control-bundle bit
//                positions and the hard-wired zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    // Default widths
    localparam int DW_DEF   = 32;
    localparam int AOPW_DEF = 3;

    // Register specifier type and the hard-wired $zero register
    typedef logic [4:0] reg_idx_t;
    localparam reg_idx_t REG_ZERO = 5'd0;

    // ALU operation encodings carried from ID to EX
    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_RTYPE = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_LUI   = 3'b110
    } aluop_e;

    // Bit positions inside the packed control bundle
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_W        = 7;

endpackage : mips_defs
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Purely combinational load-use hazard compare between the
//                instruction in EX and the instruction in ID. A load whose
//                destination is $zero never creates a hazard.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import mips_defs::*;
(
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    // Compare the load destination against both ID source operands
    always_comb begin
        rs_match = (ex_rt == id_rs);
        rt_match = id_uses_rt & (ex_rt == id_rt);
        load_use = ex_valid & ex_memread & (ex_rt != REG_ZERO) & id_valid
                 & (rs_match | rt_match);
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register. Captures operands, decoded fields
//                and control bits, inserts bubbles on load-use hazards and
//                branch flushes, freezes on downstream hold, and keeps a
//                saturating count of inserted bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import mips_defs::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AOPW = AOPW_DEF,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic [4:0]      id_rd,
    input  logic            id_uses_rt,
    input  logic [DW-1:0]   id_data1,
    input  logic [DW-1:0]   id_data2,
    input  logic [DW-1:0]   id_imm,
    input  logic [DW-1:0]   id_pc4,
    input  logic            id_ctrl_regwrite,
    input  logic            id_ctrl_memread,
    input  logic            id_ctrl_memwrite,
    input  logic            id_ctrl_memtoreg,
    input  logic            id_ctrl_alusrc,
    input  logic            id_ctrl_regdst,
    input  logic            id_ctrl_branch,
    input  logic [AOPW-1:0] id_aluop,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_rd,
    output logic [DW-1:0]   ex_data1,
    output logic [DW-1:0]   ex_data2,
    output logic [DW-1:0]   ex_imm,
    output logic [DW-1:0]   ex_pc4,
    output logic            ex_ctrl_regwrite,
    output logic            ex_ctrl_memread,
    output logic            ex_ctrl_memwrite,
    output logic            ex_ctrl_memtoreg,
    output logic            ex_ctrl_alusrc,
    output logic            ex_ctrl_regdst,
    output logic            ex_ctrl_branch,
    output logic [AOPW-1:0] ex_aluop,
    output logic [CNTW-1:0] bubble_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    // Stage register state
    logic              ex_valid_q, ex_valid_d;
    logic [4:0]        ex_rs_q,    ex_rs_d;
    logic [4:0]        ex_rt_q,    ex_rt_d;
    logic [4:0]        ex_rd_q,    ex_rd_d;
    logic [DW-1:0]     ex_data1_q, ex_data1_d;
    logic [DW-1:0]     ex_data2_q, ex_data2_d;
    logic [DW-1:0]     ex_imm_q,   ex_imm_d;
    logic [DW-1:0]     ex_pc4_q,   ex_pc4_d;
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
    logic [AOPW-1:0]   ex_aluop_q, ex_aluop_d;
    logic [CNTW-1:0]   bubble_cnt_q, bubble_cnt_d;

    logic              load_use;
    logic              count_bubble;
    logic [CTRL_W-1:0] id_ctrl;

    hazard_detect u_hazard_detect (
        .ex_valid   (ex_valid_q),
        .ex_memread (ex_ctrl_q[CTRL_MEMREAD]),
        .ex_rt      (ex_rt_q),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .load_use   (load_use)
    );

    // Pack the individual ID control bits into one bundle
    always_comb begin
        id_ctrl                = '0;
        id_ctrl[CTRL_REGWRITE] = id_ctrl_regwrite;
        id_ctrl[CTRL_MEMREAD]  = id_ctrl_memread;
        id_ctrl[CTRL_MEMWRITE] = id_ctrl_memwrite;
        id_ctrl[CTRL_MEMTOREG] = id_ctrl_memtoreg;
        id_ctrl[CTRL_ALUSRC]   = id_ctrl_alusrc;
        id_ctrl[CTRL_REGDST]   = id_ctrl_regdst;
        id_ctrl[CTRL_BRANCH]   = id_ctrl_branch;
    end

    // A flush always clears the stall; otherwise hold or hazard stalls ID
    always_comb begin
        id_stall     = (load_use | ex_hold) & ~flush;
        count_bubble = flush | (~ex_hold & load_use);
    end

    // Next stage contents: flush > hold > load-use bubble > capture
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_rd_d    = ex_rd_q;
        ex_data1_d = ex_data1_q;
        ex_data2_d = ex_data2_q;
        ex_imm_d   = ex_imm_q;
        ex_pc4_d   = ex_pc4_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_aluop_d = ex_aluop_q;
        if (flush || (!ex_hold && (load_use || !id_valid))) begin
            // Bubble: nothing in EX may write the register file or memory
            ex_valid_d = 1'b0;
            ex_rs_d    = '0;
            ex_rt_d    = '0;
            ex_rd_d    = '0;
            ex_data1_d = '0;
            ex_data2_d = '0;
            ex_imm_d   = '0;
            ex_pc4_d   = '0;
            ex_ctrl_d  = '0;
            ex_aluop_d = '0;
        end else if (!ex_hold) begin
            ex_valid_d = 1'b1;
            ex_rs_d    = id_rs;
            ex_rt_d    = id_rt;
            ex_rd_d    = id_rd;
            ex_data1_d = id_data1;
            ex_data2_d = id_data2;
            ex_imm_d   = id_imm;
            ex_pc4_d   = id_pc4;
            ex_ctrl_d  = id_ctrl;
            ex_aluop_d = id_aluop;
        end
    end

    // Stage register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_data1_q <= '0;
            ex_data2_q <= '0;
            ex_imm_q   <= '0;
            ex_pc4_q   <= '0;
            ex_ctrl_q  <= '0;
            ex_aluop_q <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            ex_data1_q <= ex_data1_d;
            ex_data2_q <= ex_data2_d;
            ex_imm_q   <= ex_imm_d;
            ex_pc4_q   <= ex_pc4_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_aluop_q <= ex_aluop_d;
        end
    end

    // Saturating increment for flush and load-use bubbles only
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (count_bubble && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid         = ex_valid_q;
    assign ex_rs            = ex_rs_q;
    assign ex_rt            = ex_rt_q;
    assign ex_rd            = ex_rd_q;
    assign ex_data1         = ex_data1_q;
    assign ex_data2         = ex_data2_q;
    assign ex_imm           = ex_imm_q;
    assign ex_pc4           = ex_pc4_q;
    assign ex_ctrl_regwrite = ex_ctrl_q[CTRL_REGWRITE];
    assign ex_ctrl_memread  = ex_ctrl_q[CTRL_MEMREAD];
    assign ex_ctrl_memwrite = ex_ctrl_q[CTRL_MEMWRITE];
    assign ex_ctrl_memtoreg = ex_ctrl_q[CTRL_MEMTOREG];
    assign ex_ctrl_alusrc   = ex_ctrl_q[CTRL_ALUSRC];
    assign ex_ctrl_regdst   = ex_ctrl_q[CTRL_REGDST];
    assign ex_ctrl_branch   = ex_ctrl_q[CTRL_BRANCH];
    assign ex_aluop         = ex_aluop_q;
    assign bubble_cnt       = bubble_cnt_q;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage: a table of directed
//                per-cycle vectors plus hand-written reset and saturation
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int DW   = 32;
    localparam int AOPW = 3;
    localparam int CNTW = 16;
    localparam int BW   = 154;

    localparam int K_CAP  = 0;
    localparam int K_BUB  = 1;
    localparam int K_HOLD = 2;

    // Control bundles, bit0 regwrite .. bit6 branch
    localparam logic [6:0] C_R   = 7'h21;
    localparam logic [6:0] C_LW  = 7'h1B;
    localparam logic [6:0] C_SW  = 7'h14;
    localparam logic [6:0] C_ADI = 7'h11;

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic        uses_rt;
        logic [31:0] d1, d2, imm, pc4;
        logic [6:0]  ctrl;
        logic [2:0]  aluop;
        logic        flush, hold;
        logic        exp_stall;
        int          kind;
        logic [15:0] exp_cnt;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid, id_uses_rt;
    logic [4:0]      id_rs, id_rt, id_rd;
    logic [DW-1:0]   id_data1, id_data2, id_imm, id_pc4;
    logic            id_ctrl_regwrite, id_ctrl_memread, id_ctrl_memwrite;
    logic            id_ctrl_memtoreg, id_ctrl_alusrc, id_ctrl_regdst, id_ctrl_branch;
    logic [AOPW-1:0] id_aluop;
    logic            flush, ex_hold;
    logic            id_stall, ex_valid;
    logic [4:0]      ex_rs, ex_rt, ex_rd;
    logic [DW-1:0]   ex_data1, ex_data2, ex_imm, ex_pc4;
    logic            ex_ctrl_regwrite, ex_ctrl_memread, ex_ctrl_memwrite;
    logic            ex_ctrl_memtoreg, ex_ctrl_alusrc, ex_ctrl_regdst, ex_ctrl_branch;
    logic [AOPW-1:0] ex_aluop;
    logic [CNTW-1:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    vec_t           tbl [24];
    logic [BW-1:0]  exp_bundle;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .AOPW(AOPW), .CNTW(CNTW)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rd            (id_rd),
        .id_uses_rt       (id_uses_rt),
        .id_data1         (id_data1),
        .id_data2         (id_data2),
        .id_imm           (id_imm),
        .id_pc4           (id_pc4),
        .id_ctrl_regwrite (id_ctrl_regwrite),
        .id_ctrl_memread  (id_ctrl_memread),
        .id_ctrl_memwrite (id_ctrl_memwrite),
        .id_ctrl_memtoreg (id_ctrl_memtoreg),
        .id_ctrl_alusrc   (id_ctrl_alusrc),
        .id_ctrl_regdst   (id_ctrl_regdst),
        .id_ctrl_branch   (id_ctrl_branch),
        .id_aluop         (id_aluop),
        .flush            (flush),
        .ex_hold          (ex_hold),
        .id_stall         (id_stall),
        .ex_valid         (ex_valid),
        .ex_rs            (ex_rs),
        .ex_rt            (ex_rt),
        .ex_rd            (ex_rd),
        .ex_data1         (ex_data1),
        .ex_data2         (ex_data2),
        .ex_imm           (ex_imm),
        .ex_pc4           (ex_pc4),
        .ex_ctrl_regwrite (ex_ctrl_regwrite),
        .ex_ctrl_memread  (ex_ctrl_memread),
        .ex_ctrl_memwrite (ex_ctrl_memwrite),
        .ex_ctrl_memtoreg (ex_ctrl_memtoreg),
        .ex_ctrl_alusrc   (ex_ctrl_alusrc),
        .ex_ctrl_regdst   (ex_ctrl_regdst),
        .ex_ctrl_branch   (ex_ctrl_branch),
        .ex_aluop         (ex_aluop),
        .bubble_cnt       (bubble_cnt)
    );

    function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic u, logic [31:0] d1, logic [31:0] d2,
                                logic [31:0] imm, logic [31:0] pc4, logic [6:0] ctrl,
                                logic [2:0] aluop, logic fl, logic hd,
                                logic es, int kind, logic [15:0] ec);
        vec_t r;
        r.valid = v;  r.rs = rs; r.rt = rt; r.rd = rd; r.uses_rt = u;
        r.d1 = d1; r.d2 = d2; r.imm = imm; r.pc4 = pc4; r.ctrl = ctrl;
        r.aluop = aluop; r.flush = fl; r.hold = hd;
        r.exp_stall = es; r.kind = kind; r.exp_cnt = ec;
        return r;
    endfunction

    function automatic logic [BW-1:0] vec_bundle(vec_t v);
        return {1'b1, v.rs, v.rt, v.rd, v.d1, v.d2, v.imm, v.pc4, v.ctrl, v.aluop};
    endfunction

    function automatic logic [BW-1:0] dut_bundle();
        return {ex_valid, ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc4,
                ex_ctrl_branch, ex_ctrl_regdst, ex_ctrl_alusrc, ex_ctrl_memtoreg,
                ex_ctrl_memwrite, ex_ctrl_memread, ex_ctrl_regwrite, ex_aluop};
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid         = v.valid;
        id_rs            = v.rs;
        id_rt            = v.rt;
        id_rd            = v.rd;
        id_uses_rt       = v.uses_rt;
        id_data1         = v.d1;
        id_data2         = v.d2;
        id_imm           = v.imm;
        id_pc4           = v.pc4;
        id_ctrl_regwrite = v.ctrl[0];
        id_ctrl_memread  = v.ctrl[1];
        id_ctrl_memwrite = v.ctrl[2];
        id_ctrl_memtoreg = v.ctrl[3];
        id_ctrl_alusrc   = v.ctrl[4];
        id_ctrl_regdst   = v.ctrl[5];
        id_ctrl_branch   = v.ctrl[6];
        id_aluop         = v.aluop;
        flush            = v.flush;
        ex_hold          = v.hold;
    endtask

    initial begin
        vec_t lw8, add8, idle;

        // valid rs rt rd uses  d1 d2 imm pc4 ctrl aluop flush hold | stall kind cnt
        tbl[0]  = mk(1, 1, 2, 3, 1, 5, 7, 0, 32'h104, C_R, 3'd2, 0, 0, 0, K_CAP, 0);
        tbl[1]  = mk(1, 1, 8, 0, 0, 32'h100, 32'h55, 4, 32'h108, C_LW, 3'd0, 0, 0, 0, K_CAP, 0);
        tbl[2]  = mk(1, 8, 10, 9, 1, 32'hAA, 32'hBB, 0, 32'h10C, C_R, 3'd2, 0, 0, 1, K_BUB, 1);
        tbl[3]  = mk(1, 8, 10, 9, 1, 32'h1234, 32'hBB, 0, 32'h10C, C_R, 3'd2, 0, 0, 0, K_CAP, 1);
        tbl[4]  = mk(1, 2, 8, 0, 0, 32'h200, 32'h66, 8, 32'h110, C_LW, 3'd0, 0, 0, 0, K_CAP, 1);
        tbl[5]  = mk(1, 4, 8, 0, 1, 32'h300, 32'h77, 0, 32'h114, C_SW, 3'd0, 0, 0, 1, K_BUB, 2);
        tbl[6]  = mk(1, 4, 8, 0, 1, 32'h300, 32'h99, 0, 32'h114, C_SW, 3'd0, 0, 0, 0, K_CAP, 2);
        tbl[7]  = mk(1, 3, 8, 0, 0, 32'h400, 32'h11, 12, 32'h118, C_LW, 3'd0, 0, 0, 0, K_CAP, 2);
        tbl[8]  = mk(1, 5, 8, 0, 0, 32'h500, 32'h22, 32'hFFFF_FFFF, 32'h11C, C_ADI, 3'd0, 0, 0, 0, K_CAP, 2);
        tbl[9]  = mk(1, 2, 0, 0, 0, 32'h600, 0, 16, 32'h120, C_LW, 3'd0, 0, 0, 0, K_CAP, 2);
        tbl[10] = mk(1, 0, 7, 5, 1, 0, 32'h700, 0, 32'h124, C_R, 3'd2, 0, 0, 0, K_CAP, 2);
        tbl[11] = mk(0, 8, 9, 10, 1, 32'hDEAD, 32'hBEEF, 5, 32'h128, C_R, 3'd2, 0, 0, 0, K_BUB, 2);
        tbl[12] = mk(1, 1, 8, 0, 0, 32'h800, 32'h33, 20, 32'h12C, C_LW, 3'd0, 0, 0, 0, K_CAP, 2);
        tbl[13] = mk(0, 8, 8, 1, 1, 32'hCAFE, 32'hF00D, 0, 32'h130, C_R, 3'd2, 0, 0, 0, K_BUB, 2);
        tbl[14] = mk(1, 1, 6, 0, 0, 32'h900, 32'h44, 24, 32'h134, C_LW, 3'd0, 0, 0, 0, K_CAP, 2);
        tbl[15] = mk(1, 6, 7, 11, 1, 32'hA00, 32'hB00, 0, 32'h138, C_R, 3'd2, 0, 1, 1, K_HOLD, 2);
        tbl[16] = mk(1, 6, 7, 11, 1, 32'hA00, 32'hB00, 0, 32'h138, C_R, 3'd2, 1, 1, 0, K_BUB, 3);
        tbl[17] = mk(1, 6, 7, 11, 1, 32'hA00, 32'hB00, 0, 32'h138, C_R, 3'd2, 0, 1, 1, K_HOLD, 3);
        tbl[18] = mk(1, 6, 7, 11, 1, 32'hA00, 32'hB00, 0, 32'h138, C_R, 3'd2, 0, 0, 0, K_CAP, 3);
        tbl[19] = mk(1, 1, 6, 0, 0, 32'h910, 32'h45, 28, 32'h13C, C_LW, 3'd0, 0, 0, 0, K_CAP, 3);
        tbl[20] = mk(1, 6, 2, 12, 1, 32'hB10, 32'hC10, 0, 32'h140, C_R, 3'd2, 0, 1, 1, K_HOLD, 3);
        tbl[21] = mk(1, 6, 2, 12, 1, 32'hB10, 32'hC10, 0, 32'h140, C_R, 3'd2, 0, 0, 1, K_BUB, 4);
        tbl[22] = mk(1, 6, 2, 12, 1, 32'hB10, 32'hC10, 0, 32'h140, C_R, 3'd2, 0, 0, 0, K_CAP, 4);
        tbl[23] = mk(1, 3, 4, 13, 1, 32'hC20, 32'hD20, 0, 32'h144, C_R, 3'd2, 1, 0, 0, K_BUB, 5);

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'h00, 3'd0, 0, 0, 0, K_BUB, 0);
        lw8  = mk(1, 1, 8, 0, 0, 32'h1000, 32'h2000, 4, 32'h200, C_LW, 3'd0, 0, 0, 0, K_CAP, 0);
        add8 = mk(1, 8, 3, 4, 1, 32'h3000, 32'h4000, 0, 32'h204, C_R, 3'd2, 0, 1, 1, K_HOLD, 0);

        // Reset state
        reset = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bundle", dut_bundle(), '0);
        chk("reset_cnt", BW'(bubble_cnt), '0);
        chk("reset_stall", BW'(id_stall), '0);
        @(negedge clk);
        reset = 1'b0;

        // Table: stall checked before the edge, stage and counter after it
        exp_bundle = '0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_stall", i), BW'(id_stall), BW'(tbl[i].exp_stall));
            @(posedge clk);
            #1;
            if (tbl[i].kind == K_BUB)
                exp_bundle = '0;
            else if (tbl[i].kind == K_CAP)
                exp_bundle = tbl[i].valid ? vec_bundle(tbl[i]) : '0;
            chk($sformatf("v%0d_ex", i), dut_bundle(), exp_bundle);
            chk($sformatf("v%0d_cnt", i), BW'(bubble_cnt), BW'(tbl[i].exp_cnt));
        end

        // Reset mid-stall: a reset pulse between edges is ignored
        @(negedge clk);
        drive(lw8);
        @(posedge clk);
        @(negedge clk);
        drive(add8);
        #1;
        chk("mid_stall", BW'(id_stall), 1);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("pulse_ex", dut_bundle(), vec_bundle(lw8));
        chk("pulse_cnt", BW'(bubble_cnt), 5);
        @(negedge clk);
        ex_hold = 1'b0;
        reset   = 1'b1;
        #1;
        chk("pre_rst_stall", BW'(id_stall), 1);
        @(posedge clk);
        #1;
        chk("rst_ex", dut_bundle(), '0);
        chk("rst_cnt", BW'(bubble_cnt), '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_stall", BW'(id_stall), '0);

        // Saturation: 2^CNTW + 3 flush bubbles
        flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", BW'(bubble_cnt), 16'hFFFE);
        @(posedge clk);
        #1;
        chk("sat_ffff", BW'(bubble_cnt), 16'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        chk("sat_hold", BW'(bubble_cnt), 16'hFFFF);
        chk("sat_ex", dut_bundle(), '0);
        @(negedge clk);
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire
